// File: rtl/jttrack_sndlatch.sv
// jttrack_sndlatch
// Sound-side receiver for the main-to-sound command path. Bytes written by
// the main CPU are queued in a small FIFO so back-to-back commands survive
// while the sound CPU is stalled. Main CPU interrupt requests become a
// pending interrupt for the sound CPU.
//
// Parameters:
//   AW       FIFO address width, depth = 2**AW entries
//   IRQ_HOLD 1: interrupt stays pending until the FIFO is empty
//            0: interrupt clears on irq_ack
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   main_dout  main CPU data bus, captured on a m2s_data rising edge
//   m2s_data   main CPU latch-write strobe (level)
//   m2s_irq    main CPU interrupt request (level)
//   snd_rd     sound CPU latch-read strobe (level), pops on its falling edge
//   irq_ack    sound CPU interrupt acknowledge (single-clk pulse)
//   snd_dout   registered FIFO head byte
//   snd_irqn   interrupt to sound CPU, active low
//   empty      FIFO empty
//   full       FIFO full
//   ovf        sticky overflow flag, cleared only by reset
module jttrack_sndlatch #(
    parameter int AW       = 2,
    parameter int IRQ_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] main_dout,
    input  logic       m2s_data,
    input  logic       m2s_irq,
    input  logic       snd_rd,
    input  logic       irq_ack,
    output logic [7:0] snd_dout,
    output logic       snd_irqn,
    output logic       empty,
    output logic       full,
    output logic       ovf
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic {
        IDLE,
        PEND
    } irq_state_t;

    logic          data_q;
    logic          irq_q;
    logic          rd_q;
    logic          push_edge;
    logic          irq_edge;
    logic          pop_edge;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          empty_next;
    logic [7:0]    mem [0:(1<<AW)-1];
    irq_state_t    state;
    irq_state_t    state_next;

    // Previous-cycle copies of the strobes for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 1'b0;
            irq_q  <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            data_q <= m2s_data;
            irq_q  <= m2s_irq;
            rd_q   <= snd_rd;
        end
    end

    assign push_edge = m2s_data & ~data_q;
    assign irq_edge  = m2s_irq & ~irq_q;
    // Pop at the end of the read so snd_dout is stable for the whole access
    assign pop_edge  = ~snd_rd & rd_q;

    assign pop_ok  = pop_edge & ~empty;
    // A pop in the same clock frees a slot, so a push while full is accepted
    assign push_ok = push_edge & (~full | pop_ok);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    assign empty_next = (count_next == '0);

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            empty <= empty_next;
            full  <= (count_next == FULL_CNT);
            if (push_edge && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= main_dout;
        end
    end

    // Head byte follows mem[rd_ptr] one clock late; frozen while empty so the
    // last popped value remains visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_dout <= 8'h00;
        end else if (!empty) begin
            snd_dout <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new request in the acknowledge cycle keeps the interrupt pending
    always_comb begin
        state_next = state;
        snd_irqn   = 1'b1;
        case (state)
            IDLE: begin
                if (irq_edge) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                snd_irqn = 1'b0;
                if (!irq_edge && irq_ack) begin
                    if (IRQ_HOLD == 0 || empty || empty_next) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jttrack_sndlatch.sv
// tb_jttrack_sndlatch
// Drives two instances (IRQ_HOLD=0 and IRQ_HOLD=1) with identical stimulus.
// Written bytes go into a scoreboard queue and are compared against the
// head byte when the sound side reads them back.
module tb_jttrack_sndlatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] main_dout;
    logic       m2s_data;
    logic       m2s_irq;
    logic       snd_rd;
    logic       irq_ack;

    logic [7:0] dout0, dout1;
    logic       irqn0, irqn1;
    logic       empty0, empty1;
    logic       full0, full1;
    logic       ovf0, ovf1;

    int         n_compared   = 0;
    int         n_mismatched = 0;

    logic [7:0] exp_q [$];
    logic       exp_ovf;
    logic [7:0] exp_last;

    always #5 clk = ~clk;

    jttrack_sndlatch #(.AW(2), .IRQ_HOLD(0)) dut_hold0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .main_dout (main_dout),
        .m2s_data  (m2s_data),
        .m2s_irq   (m2s_irq),
        .snd_rd    (snd_rd),
        .irq_ack   (irq_ack),
        .snd_dout  (dout0),
        .snd_irqn  (irqn0),
        .empty     (empty0),
        .full      (full0),
        .ovf       (ovf0)
    );

    jttrack_sndlatch #(.AW(2), .IRQ_HOLD(1)) dut_hold1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .main_dout (main_dout),
        .m2s_data  (m2s_data),
        .m2s_irq   (m2s_irq),
        .snd_rd    (snd_rd),
        .irq_ack   (irq_ack),
        .snd_dout  (dout1),
        .snd_irqn  (irqn1),
        .empty     (empty1),
        .full      (full1),
        .ovf       (ovf1)
    );

    // Advance n clocks, landing 1ns after the rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic got, input logic exp);
        checkOutput(tag, {7'b0, got}, {7'b0, exp});
    endtask

    // Compare both instances' FIFO-side outputs against the scoreboard
    task automatic checkFifo(input string tag);
        logic [7:0] head;
        logic       mt;
        logic       fl;
        mt   = (exp_q.size() == 0);
        fl   = (exp_q.size() == 4);
        head = mt ? exp_last : exp_q[0];
        checkFlag({tag, "_empty0"}, empty0, mt);
        checkFlag({tag, "_full0"}, full0, fl);
        checkFlag({tag, "_ovf0"}, ovf0, exp_ovf);
        checkOutput({tag, "_dout0"}, dout0, head);
        checkFlag({tag, "_empty1"}, empty1, mt);
        checkOutput({tag, "_dout1"}, dout1, head);
    endtask

    task automatic modelReset();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_last = 8'h00;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        m2s_data  = 1'b0;
        m2s_irq   = 1'b0;
        snd_rd    = 1'b0;
        irq_ack   = 1'b0;
        main_dout = 8'h00;
        cyc(2);
        rst_n = 1'b1;
        modelReset();
        cyc(1);
    endtask

    // Write one byte with a strobe held for 'hold' clocks
    task automatic applyStimulus(input logic [7:0] d, input int hold);
        main_dout = d;
        m2s_data  = 1'b1;
        cyc(1);
        if (exp_q.size() < 4) begin
            exp_q.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
        if (hold > 1) begin
            cyc(hold - 1);
        end
        m2s_data = 1'b0;
        cyc(1);
    endtask

    // Full read cycle: data checked while snd_rd is high, pop on release
    task automatic readByte(input string tag);
        snd_rd = 1'b1;
        cyc(2);
        if (exp_q.size() > 0) begin
            checkOutput({tag, "_rd"}, dout0, exp_q[0]);
        end
        snd_rd = 1'b0;
        cyc(1);
        if (exp_q.size() > 0) begin
            exp_last = exp_q.pop_front();
        end
        cyc(1);
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        modelReset();
        doReset();

        // 1: reset values, then a 3-clock write strobe yields one entry
        checkFlag("rst_irqn0", irqn0, 1'b1);
        checkFlag("rst_irqn1", irqn1, 1'b1);
        checkFifo("rst");
        main_dout = 8'hA5;
        m2s_data  = 1'b1;
        cyc(1);
        exp_q.push_back(8'hA5);
        checkFlag("a5_empty_edge", empty0, 1'b0);
        cyc(1);
        checkOutput("a5_dout_edge1", dout0, 8'hA5);
        cyc(1);
        m2s_data = 1'b0;
        cyc(1);
        checkFifo("a5");
        readByte("a5");
        checkFifo("a5_drained");

        // 2: fill, overflow, drain in order
        doReset();
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 2);
        applyStimulus(8'h33, 1);
        applyStimulus(8'h44, 3);
        checkFifo("fill4");
        applyStimulus(8'h55, 1);
        checkFifo("ovf");
        for (int i = 0; i < 4; i++) begin
            readByte("drain");
        end
        checkFifo("drain_done");
        readByte("pop_empty");
        checkFifo("pop_empty");

        // 3: push and pop in the same clock while full
        doReset();
        applyStimulus(8'h61, 1);
        applyStimulus(8'h62, 1);
        applyStimulus(8'h63, 1);
        applyStimulus(8'h64, 1);
        checkFifo("full_again");
        snd_rd = 1'b1;
        cyc(2);
        checkOutput("simul_rd", dout0, exp_q[0]);
        main_dout = 8'h65;
        m2s_data  = 1'b1;
        snd_rd    = 1'b0;
        cyc(1);
        exp_last = exp_q.pop_front();
        exp_q.push_back(8'h65);
        m2s_data = 1'b0;
        cyc(1);
        checkFifo("simul");
        for (int i = 0; i < 4; i++) begin
            readByte("wrap");
        end
        checkFifo("wrap_done");

        // 4: IRQ request / acknowledge, and request coincident with ack
        doReset();
        m2s_irq = 1'b1;
        cyc(1);
        checkFlag("irq_set0", irqn0, 1'b0);
        checkFlag("irq_set1", irqn1, 1'b0);
        cyc(2);
        m2s_irq = 1'b0;
        cyc(1);
        pulseAck();
        checkFlag("irq_ack0", irqn0, 1'b1);
        checkFlag("irq_ack1", irqn1, 1'b1);
        m2s_irq = 1'b1;
        cyc(1);
        m2s_irq = 1'b0;
        cyc(1);
        m2s_irq = 1'b1;
        pulseAck();
        checkFlag("irq_race0", irqn0, 1'b0);
        checkFlag("irq_race1", irqn1, 1'b0);
        m2s_irq = 1'b0;
        cyc(1);
        pulseAck();
        checkFlag("irq_clr0", irqn0, 1'b1);
        checkFlag("irq_clr1", irqn1, 1'b1);

        // 5: hold mode keeps IRQ pending until the FIFO drains
        applyStimulus(8'h31, 1);
        applyStimulus(8'h32, 1);
        m2s_irq = 1'b1;
        cyc(1);
        m2s_irq = 1'b0;
        checkFlag("hold_set1", irqn1, 1'b0);
        pulseAck();
        checkFlag("hold_ack0", irqn0, 1'b1);
        checkFlag("hold_ack1", irqn1, 1'b0);
        readByte("hold");
        readByte("hold");
        checkFifo("hold_drained");
        checkFlag("hold_still1", irqn1, 1'b0);
        pulseAck();
        checkFlag("hold_clr1", irqn1, 1'b1);

        // 6: asynchronous reset in the middle of a clock period
        doReset();
        applyStimulus(8'h01, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h03, 1);
        m2s_irq = 1'b1;
        cyc(1);
        m2s_irq = 1'b0;
        checkFlag("pre_rst_irqn0", irqn0, 1'b0);
        checkFlag("pre_rst_empty", empty0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkFlag("async_irqn0", irqn0, 1'b1);
        checkFlag("async_irqn1", irqn1, 1'b1);
        checkFifo("async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        applyStimulus(8'h7E, 2);
        checkFifo("post_rst");
        readByte("post_rst");
        checkFifo("post_rst_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
